// File: rtl/uart_tx.sv
// UART transmitter fed from an upstream FIFO: pops one byte per frame and
// serialises start, 8 data bits LSB first, optional even parity and stop.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] fifo_data,
  input  logic       fifo_emp,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    IDLE, READ, CAPTURE, START, DATA, PARITY, STOP
  } state_t;

  state_t        state;
  logic [BW-1:0] baud;
  logic [2:0]    bitidx;
  logic [7:0]    shreg;

  // Outputs are assigned together with the transition into the state that
  // owns them, so each one is a plain register matching the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      fifo_rd <= 1'b0;
      busy    <= 1'b0;
      tx_done <= 1'b0;
      baud    <= '0;
      bitidx  <= '0;
      shreg   <= '0;
    end else begin
      fifo_rd <= 1'b0;
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!fifo_emp) begin
            state   <= READ;
            fifo_rd <= 1'b1;
            busy    <= 1'b1;
          end
        end
        READ: state <= CAPTURE;
        CAPTURE: begin
          shreg <= fifo_data;
          baud  <= '0;
          tx    <= 1'b0;
          state <= START;
        end
        START: begin
          if (baud == BAUD_LAST) begin
            baud   <= '0;
            bitidx <= '0;
            tx     <= shreg[0];
            state  <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (bitidx == 3'd7) begin
              bitidx <= '0;
              if (PARITY_EN != 0) begin
                tx    <= ^shreg;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bitidx <= bitidx + 3'd1;
              tx     <= shreg[bitidx + 3'd1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        PARITY: begin
          if (baud == BAUD_LAST) begin
            baud  <= '0;
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          // Raised one cycle early so the registered pulse lands on the final stop cycle.
          if (baud == BAUD_PRE) tx_done <= 1'b1;
          if (baud == BAUD_LAST) begin
            baud  <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances cover CLKS_PER_BIT=4 without and
// with parity, and CLKS_PER_BIT=2.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data [3];
  logic       emp  [3];
  logic       rd   [3];
  logic       tx_w [3];
  logic       bsy  [3];
  logic       done [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0)) dut0 (
    .clk(clk), .rst(rst), .fifo_data(data[0]), .fifo_emp(emp[0]),
    .fifo_rd(rd[0]), .tx(tx_w[0]), .busy(bsy[0]), .tx_done(done[0]));
  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) dut1 (
    .clk(clk), .rst(rst), .fifo_data(data[1]), .fifo_emp(emp[1]),
    .fifo_rd(rd[1]), .tx(tx_w[1]), .busy(bsy[1]), .tx_done(done[1]));
  uart_tx #(.CLKS_PER_BIT(2), .PARITY_EN(0)) dut2 (
    .clk(clk), .rst(rst), .fifo_data(data[2]), .fifo_emp(emp[2]),
    .fifo_rd(rd[2]), .tx(tx_w[2]), .busy(bsy[2]), .tx_done(done[2]));

  typedef struct {
    int         sel;
    int         clks;
    int         pen;
    logic [7:0] b;
    logic       par;
    int         flen;
  } vec_t;

  vec_t vt [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   nbits;
    int   done_at;
    int   ndone;
    int   k;
    logic expb;
    logic ok;
    nbits   = v.flen / v.clks;
    done_at = -1;
    ndone   = 0;
    ok      = 1'b1;
    data[v.sel] = v.b;
    emp[v.sel]  = 1'b0;          // cycle N
    tick();                      // N+1
    chk("rd_pulse", 32'(rd[v.sel]), 32'd1);
    emp[v.sel] = 1'b1;
    tick();                      // N+2
    chk("rd_single", 32'(rd[v.sel]), 32'd0);
    chk("tx_high_capture", 32'(tx_w[v.sel]), 32'd1);
    tick();                      // N+3: first start-bit cycle
    for (int cyc = 0; cyc < v.flen; cyc++) begin
      if (cyc == 0) data[v.sel] = ~v.b;
      k = cyc / v.clks;
      if (k == 0)                        expb = 1'b0;
      else if (k <= 8)                   expb = v.b[k-1];
      else if (k == 9 && v.pen != 0)     expb = v.par;
      else                               expb = 1'b1;
      if (tx_w[v.sel] !== expb) ok = 1'b0;
      if (done[v.sel] === 1'b1) begin
        ndone++;
        done_at = cyc;
      end
      if ((cyc % v.clks) == v.clks - 1) begin
        chk($sformatf("bit%0d_of_%0h", k, v.b), 32'(ok), 32'd1);
        ok = 1'b1;
      end
      if (k < nbits - 1) chk("busy_in_frame", 32'(bsy[v.sel]), 32'd1);
      tick();
    end
    chk("tx_done_last_cycle", 32'(done_at), 32'(v.flen - 1));
    chk("tx_done_count", 32'(ndone), 32'd1);
    chk("busy_low_after", 32'(bsy[v.sel]), 32'd0);
    chk("tx_idle_after", 32'(tx_w[v.sel]), 32'd1);
    chk("no_extra_rd", 32'(rd[v.sel]), 32'd0);
  endtask

  initial begin
    logic [7:0] q   [8];
    logic [7:0] got [8];
    logic [7:0] sh;
    logic       emp_at_edge;
    int rds, late_rd, nrx, pos, gap, bad_rd, bad_tx;
    logic infr;

    for (int i = 0; i < 3; i++) begin
      emp[i]  = 1'b1;
      data[i] = 8'h00;
    end
    vt[0] = '{sel: 0, clks: 4, pen: 0, b: 8'h44, par: 1'b0, flen: 40};
    vt[1] = '{sel: 0, clks: 4, pen: 0, b: 8'hA5, par: 1'b0, flen: 40};
    vt[2] = '{sel: 1, clks: 4, pen: 1, b: 8'h07, par: 1'b1, flen: 44};
    vt[3] = '{sel: 1, clks: 4, pen: 1, b: 8'h77, par: 1'b0, flen: 44};
    vt[4] = '{sel: 2, clks: 2, pen: 0, b: 8'hFF, par: 1'b0, flen: 20};
    vt[5] = '{sel: 2, clks: 2, pen: 0, b: 8'h00, par: 1'b0, flen: 20};
    q = '{8'h44, 8'h55, 8'h22, 8'h24, 8'h77, 8'h56, 8'h09, 8'h45};

    // Asynchronous reset before the first clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_tx", 32'(tx_w[0]), 32'd1);
    chk("rst_rd", 32'(rd[0]), 32'd0);
    chk("rst_busy", 32'(bsy[0]), 32'd0);
    chk("rst_done", 32'(done[0]), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    bad_rd = 0;
    bad_tx = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (rd[0] !== 1'b0) bad_rd++;
      if (tx_w[0] !== 1'b1) bad_tx++;
    end
    chk("idle_no_rd", 32'(bad_rd), 32'd0);
    chk("idle_tx_high", 32'(bad_tx), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    // Burst of eight bytes with the FIFO draining behind the transmitter
    rds = 0; late_rd = 0; nrx = 0; pos = 0; gap = 0; infr = 1'b0; sh = '0;
    data[0] = 8'h00;
    emp[0]  = 1'b0;
    for (int cyc = 0; cyc < 420; cyc++) begin
      emp_at_edge = emp[0];
      tick();
      if (rd[0] === 1'b1) begin
        if (emp_at_edge) late_rd++;
        if (rds < 8) data[0] = q[rds];
        rds++;
        if (rds >= 8) emp[0] = 1'b1;
      end
      if (!infr && tx_w[0] === 1'b0) begin
        infr = 1'b1;
        pos  = 0;
        if (nrx > 0) chk($sformatf("gap_before_frame%0d", nrx), 32'(gap), 32'd3);
      end else if (!infr) begin
        gap++;
      end
      if (infr) begin
        if (pos >= 6 && pos <= 34 && (pos % 4) == 2) sh[(pos - 6) / 4] = tx_w[0];
        if (pos == 39) begin
          infr = 1'b0;
          if (nrx < 8) got[nrx] = sh;
          nrx++;
          gap = 0;
        end
        pos++;
      end
    end
    chk("burst_rd_count", 32'(rds), 32'd8);
    chk("burst_rd_when_empty", 32'(late_rd), 32'd0);
    chk("burst_frames", 32'(nrx), 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("burst_byte%0d", i), 32'(got[i]), 32'(q[i]));

    // Reset during data bit 3 of 0x55
    data[0] = 8'h55;
    emp[0]  = 1'b0;
    tick();                      // N+1
    emp[0] = 1'b1;
    repeat (19) tick();          // N+20: second cycle of data bit 3
    chk("bit3_before_rst", 32'(tx_w[0]), 32'd0);
    chk("busy_before_rst", 32'(bsy[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_tx", 32'(tx_w[0]), 32'd1);
    chk("midrst_busy", 32'(bsy[0]), 32'd0);
    chk("midrst_rd", 32'(rd[0]), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    bad_rd = 0;
    bad_tx = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (rd[0] !== 1'b0) bad_rd++;
      if (tx_w[0] !== 1'b1 || bsy[0] !== 1'b0) bad_tx++;
    end
    chk("post_rst_no_rd", 32'(bad_rd), 32'd0);
    chk("post_rst_idle", 32'(bad_tx), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, giving clk cycles per serial bit, legal range >= 2.
REQ-002 The block SHALL have parameter PARITY_EN, default 0: 0 = no parity bit, 1 = even parity bit after the data bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 fifo_data  input  8  byte from the upstream FIFO, valid the cycle after fifo_rd is high.
REQ-006 fifo_emp  input  1  upstream FIFO empty flag.
REQ-007 fifo_rd  output  1  registered one-cycle pop strobe to the upstream FIFO.
REQ-008 tx  output  1  serial line, idle high.
REQ-009 busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 tx_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Function
REQ-011 The FSM SHALL have states IDLE, READ, CAPTURE, START, DATA, PARITY, STOP.
REQ-012 IDLE: tx=1, fifo_rd=0, busy=0; fifo_emp sampled 0 -> READ; fifo_emp sampled 1 -> stay IDLE.
REQ-013 READ: fifo_rd=1 for exactly this one cycle; next state CAPTURE unconditionally.
REQ-014 CAPTURE: fifo_rd=0; fifo_data latched into the shift register at the end of this cycle; next state START.
REQ-015 Latency: fifo_emp sampled low in IDLE at cycle N -> fifo_rd high in N+1 -> tx low from N+3.
REQ-016 START drives tx=0, DATA drives the 8 bits LSB first, PARITY (only if PARITY_EN=1) drives XOR of the 8 latched bits, STOP drives tx=1.
REQ-017 Each of START, each data bit, PARITY and STOP SHALL last exactly CLKS_PER_BIT cycles, timed by a baud counter 0..CLKS_PER_BIT-1 of width clog2(CLKS_PER_BIT) that clears on every bit boundary.
REQ-018 Frame length from first START cycle to last STOP cycle SHALL be (10+PARITY_EN)*CLKS_PER_BIT cycles.
REQ-019 A 3-bit bit index SHALL count data bits 0..7; after bit 7 -> PARITY if PARITY_EN=1, else STOP.
REQ-020 tx_done SHALL be high only on the final STOP cycle; next state is IDLE.
REQ-021 Back-to-back frames: with fifo_emp low continuously, tx SHALL stay high for exactly 3 cycles (IDLE, READ, CAPTURE) between a stop bit and the next start bit.
REQ-022 fifo_emp SHALL be ignored outside IDLE; fifo_rd SHALL never pulse when fifo_emp was sampled high.
REQ-023 fifo_data SHALL be sampled only in CAPTURE; changes elsewhere SHALL not affect tx.
REQ-024 fifo_rd SHALL pulse exactly once per transmitted frame.
REQ-025 tx SHALL be registered and glitch-free.

Reset
REQ-026 rst high SHALL force immediately, without waiting for clk: state IDLE, tx=1, fifo_rd=0, busy=0, tx_done=0, baud counter, bit index and shift register 0.
REQ-027 Reset mid-frame SHALL abort the frame; the popped byte is discarded and not retransmitted.
REQ-028 After rst deasserts, the first IDLE sample of fifo_emp SHALL occur on the first rising clk edge.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-029 Assert rst with outputs unknown -> tx=1, fifo_rd=0, busy=0, tx_done=0 before the next clk edge; hold fifo_emp=1 for 200 cycles -> no fifo_rd, tx constant 1.
REQ-030 Single byte 0x44, fifo_emp falls at cycle N -> fifo_rd high only in N+1; tx from N+3 = 0 | 0,0,1,0,0,0,1,0 | 1, each bit 4 cycles; tx_done in cycle N+42; busy low from N+43.
REQ-031 Burst 0x44,0x55,0x22,0x24,0x77,0x56,0x09,0x45 with fifo_emp low until drained -> 8 fifo_rd pulses, bytes reconstructed in order, 3-cycle high gap between frames, no fifo_rd after fifo_emp rises.
REQ-032 PARITY_EN=1: byte 0x07 -> parity bit 1; byte 0x77 -> parity bit 0; frame 44 cycles each.
REQ-033 rst pulsed during data bit 3 of 0x55 -> tx=1 and busy=0 asynchronously; after release with fifo_emp=1 the block stays idle with no fifo_rd.
REQ-034 CLKS_PER_BIT=2, byte 0xFF -> start bit 2 cycles low, 16 cycles high data, stop 2 cycles; frame 20 cycles.
